// File: rtl/noc_switch_allocator.sv
// Separable input-first switch allocator for one mesh router: per-input VC round-robin,
// then per-output input round-robin, with per-output-VC credit tracking and registered grants.
module noc_switch_allocator #(
    parameter int PORT_NUM    = 5,
    parameter int VC_NUM      = 4,
    parameter int BUFFER_SIZE = 8,
    parameter int PORT_SIZE   = $clog2(PORT_NUM),
    parameter int VC_SIZE     = $clog2(VC_NUM),
    parameter int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [PORT_NUM*VC_NUM-1:0]            req_i,
    input  logic [PORT_NUM*VC_NUM*PORT_SIZE-1:0]  out_port_i,
    input  logic [PORT_NUM*VC_NUM*VC_SIZE-1:0]    out_vc_i,
    input  logic [PORT_NUM-1:0]                   credit_valid_i,
    input  logic [PORT_NUM*VC_SIZE-1:0]           credit_vc_i,
    output logic [PORT_NUM-1:0]                   grant_valid_o,
    output logic [PORT_NUM*VC_SIZE-1:0]           grant_vc_o,
    output logic [PORT_NUM-1:0]                   xbar_valid_o,
    output logic [PORT_NUM*PORT_SIZE-1:0]         xbar_sel_o,
    output logic                                  credit_err_o
);

    localparam logic [CNT_W-1:0]     CREDIT_MAX = CNT_W'(BUFFER_SIZE);
    localparam logic [PORT_SIZE-1:0] PORT_LAST  = PORT_SIZE'(PORT_NUM - 1);
    localparam logic [VC_SIZE-1:0]   VC_LAST    = VC_SIZE'(VC_NUM - 1);

    logic [CNT_W-1:0]           credit_r      [PORT_NUM][VC_NUM];
    logic [CNT_W-1:0]           credit_next_s [PORT_NUM][VC_NUM];
    logic [VC_SIZE-1:0]         in_ptr_r      [PORT_NUM];
    logic [PORT_SIZE-1:0]       out_ptr_r     [PORT_NUM];
    logic [PORT_NUM-1:0]        grant_valid_r;
    logic [PORT_NUM*VC_SIZE-1:0] grant_vc_r;
    logic [PORT_NUM-1:0]        xbar_valid_r;
    logic [PORT_NUM*PORT_SIZE-1:0] xbar_sel_r;
    logic                       credit_err_r;

    logic [PORT_NUM*VC_NUM-1:0] elig_s;
    logic [PORT_NUM-1:0]        s1_valid_s;
    logic [VC_SIZE-1:0]         s1_vc_s   [PORT_NUM];
    logic [PORT_SIZE-1:0]       s1_port_s [PORT_NUM];
    logic [VC_SIZE-1:0]         s1_ovc_s  [PORT_NUM];
    logic [PORT_NUM-1:0]        s2_valid_s;
    logic [PORT_SIZE-1:0]       s2_in_s   [PORT_NUM];
    logic [VC_SIZE-1:0]         gnt_ovc_s [PORT_NUM];
    logic [PORT_NUM-1:0]        win_s;
    logic                       err_set_s;

    // Eligibility: valid request, legal port, downstream credit, and not granted last cycle
    always_comb begin
        logic [PORT_SIZE-1:0] tgt_port_s;
        logic [VC_SIZE-1:0]   tgt_vc_s;
        logic                 masked_s;
        elig_s     = '0;
        tgt_port_s = '0;
        tgt_vc_s   = '0;
        masked_s   = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                tgt_port_s = out_port_i[(i*VC_NUM+v)*PORT_SIZE +: PORT_SIZE];
                tgt_vc_s   = out_vc_i[(i*VC_NUM+v)*VC_SIZE +: VC_SIZE];
                masked_s   = grant_valid_r[i] && (grant_vc_r[i*VC_SIZE +: VC_SIZE] == VC_SIZE'(v));
                if (req_i[i*VC_NUM+v] && !masked_s && (tgt_port_s <= PORT_LAST)) begin
                    elig_s[i*VC_NUM+v] = (credit_r[tgt_port_s][tgt_vc_s] != '0);
                end else begin
                    elig_s[i*VC_NUM+v] = 1'b0;
                end
            end
        end
    end

    // Stage 1: per input, first eligible VC at or after in_ptr
    always_comb begin
        int v_s;
        v_s        = 0;
        s1_valid_s = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            s1_vc_s[i]   = '0;
            s1_port_s[i] = '0;
            s1_ovc_s[i]  = '0;
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                v_s = (int'(in_ptr_r[i]) + k) % VC_NUM;
                if (!s1_valid_s[i] && elig_s[i*VC_NUM+v_s]) begin
                    s1_valid_s[i] = 1'b1;
                    s1_vc_s[i]    = VC_SIZE'(v_s);
                    s1_port_s[i]  = out_port_i[(i*VC_NUM+v_s)*PORT_SIZE +: PORT_SIZE];
                    s1_ovc_s[i]   = out_vc_i[(i*VC_NUM+v_s)*VC_SIZE +: VC_SIZE];
                end else begin
                    s1_valid_s[i] = s1_valid_s[i];
                end
            end
        end
    end

    // Stage 2: per output, first stage-1 winner at or after out_ptr that targets it
    always_comb begin
        int i_s;
        i_s        = 0;
        s2_valid_s = '0;
        win_s      = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            s2_in_s[o]   = '0;
            gnt_ovc_s[o] = '0;
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int k = 0; k < PORT_NUM; k++) begin
                i_s = (int'(out_ptr_r[o]) + k) % PORT_NUM;
                if (!s2_valid_s[o] && s1_valid_s[i_s] && (s1_port_s[i_s] == PORT_SIZE'(o))) begin
                    s2_valid_s[o] = 1'b1;
                    s2_in_s[o]    = PORT_SIZE'(i_s);
                    gnt_ovc_s[o]  = s1_ovc_s[i_s];
                    win_s[i_s]    = 1'b1;
                end else begin
                    s2_valid_s[o] = s2_valid_s[o];
                end
            end
        end
    end

    // Credit next-state: grant and return in the same cycle cancel; a return to a full counter is an error
    always_comb begin
        logic inc_s;
        logic dec_s;
        inc_s     = 1'b0;
        dec_s     = 1'b0;
        err_set_s = 1'b0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int c = 0; c < VC_NUM; c++) begin
                dec_s = s2_valid_s[o] && (gnt_ovc_s[o] == VC_SIZE'(c));
                inc_s = credit_valid_i[o] && (credit_vc_i[o*VC_SIZE +: VC_SIZE] == VC_SIZE'(c));
                case ({inc_s, dec_s})
                    2'b10: begin
                        if (credit_r[o][c] == CREDIT_MAX) begin
                            credit_next_s[o][c] = credit_r[o][c];
                            err_set_s           = 1'b1;
                        end else begin
                            credit_next_s[o][c] = credit_r[o][c] + CNT_W'(1);
                        end
                    end
                    2'b01:   credit_next_s[o][c] = credit_r[o][c] - CNT_W'(1);
                    default: credit_next_s[o][c] = credit_r[o][c];
                endcase
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_valid_r <= '0;
            grant_vc_r    <= '0;
            xbar_valid_r  <= '0;
            xbar_sel_r    <= '0;
            credit_err_r  <= 1'b0;
            for (int p = 0; p < PORT_NUM; p++) begin
                in_ptr_r[p]  <= '0;
                out_ptr_r[p] <= '0;
                for (int c = 0; c < VC_NUM; c++) begin
                    credit_r[p][c] <= CREDIT_MAX;
                end
            end
        end else begin
            grant_valid_r <= win_s;
            xbar_valid_r  <= s2_valid_s;
            credit_err_r  <= credit_err_r | err_set_s;
            for (int p = 0; p < PORT_NUM; p++) begin
                grant_vc_r[p*VC_SIZE +: VC_SIZE]   <= win_s[p] ? s1_vc_s[p] : '0;
                xbar_sel_r[p*PORT_SIZE +: PORT_SIZE] <= s2_valid_s[p] ? s2_in_s[p] : '0;
                if (win_s[p]) begin
                    in_ptr_r[p] <= (s1_vc_s[p] == VC_LAST) ? '0 : s1_vc_s[p] + VC_SIZE'(1);
                end
                if (s2_valid_s[p]) begin
                    out_ptr_r[p] <= (s2_in_s[p] == PORT_LAST) ? '0 : s2_in_s[p] + PORT_SIZE'(1);
                end
                for (int c = 0; c < VC_NUM; c++) begin
                    credit_r[p][c] <= credit_next_s[p][c];
                end
            end
        end
    end

    assign grant_valid_o = grant_valid_r;
    assign grant_vc_o    = grant_vc_r;
    assign xbar_valid_o  = xbar_valid_r;
    assign xbar_sel_o    = xbar_sel_r;
    assign credit_err_o  = credit_err_r;

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Bench for noc_switch_allocator: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a distance-based round-robin model.
module tb_noc_switch_allocator;

    localparam int P  = 5;
    localparam int V  = 4;
    localparam int PS = 3;
    localparam int VS = 2;
    localparam int BS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [P*V-1:0]    req_s;
    logic [P*V*PS-1:0] out_port_s;
    logic [P*V*VS-1:0] out_vc_s;
    logic [P-1:0]      credit_valid_s;
    logic [P*VS-1:0]   credit_vc_s;
    logic [P-1:0]      grant_valid_s;
    logic [P*VS-1:0]   grant_vc_s;
    logic [P-1:0]      xbar_valid_s;
    logic [P*PS-1:0]   xbar_sel_s;
    logic              credit_err_s;

    logic        req_a  [P][V];
    logic [2:0]  port_a [P][V];
    logic [1:0]  vc_a   [P][V];
    logic        cv_a   [P];
    logic [1:0]  cvc_a  [P];

    int credit_m [P][V];
    int in_ptr_m [P];
    int out_ptr_m[P];
    int gv_m[P], gvc_m[P], xv_m[P], xsel_m[P];
    int err_m;

    logic [P-1:0]    exp_gv;
    logic [P*VS-1:0] exp_gvc;
    logic [P-1:0]    exp_xv;
    logic [P*PS-1:0] exp_xsel;
    logic            exp_err;

    int n_chk = 0;
    int n_err = 0;
    int cnt;
    int seq[4];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < P; i++) begin
            for (int v = 0; v < V; v++) begin
                req_s[i*V+v]               = req_a[i][v];
                out_port_s[(i*V+v)*PS +: PS] = port_a[i][v];
                out_vc_s[(i*V+v)*VS +: VS]   = vc_a[i][v];
            end
            credit_valid_s[i]        = cv_a[i];
            credit_vc_s[i*VS +: VS]  = cvc_a[i];
        end
    end

    noc_switch_allocator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_s),
        .out_port_i     (out_port_s),
        .out_vc_i       (out_vc_s),
        .credit_valid_i (credit_valid_s),
        .credit_vc_i    (credit_vc_s),
        .grant_valid_o  (grant_valid_s),
        .grant_vc_o     (grant_vc_s),
        .xbar_valid_o   (xbar_valid_s),
        .xbar_sel_o     (xbar_sel_s),
        .credit_err_o   (credit_err_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Model: predicts the outputs after the coming edge and advances its own state.
    task automatic predict();
        int s1[P];
        int pgv[P];
        int pgvc[P];
        int delta[P][V];
        int bd, d, port, ovc, w, c;
        for (int i = 0; i < P; i++) begin
            pgv[i]  = gv_m[i];
            pgvc[i] = gvc_m[i];
            gv_m[i] = 0; gvc_m[i] = 0; xv_m[i] = 0; xsel_m[i] = 0;
            for (int v = 0; v < V; v++) delta[i][v] = 0;
        end
        if (!rst_n) begin
            err_m = 0;
            for (int i = 0; i < P; i++) begin
                in_ptr_m[i] = 0;
                out_ptr_m[i] = 0;
                for (int v = 0; v < V; v++) credit_m[i][v] = BS;
            end
        end else begin
            for (int i = 0; i < P; i++) begin
                s1[i] = -1;
                bd = V;
                for (int v = 0; v < V; v++) begin
                    port = int'(port_a[i][v]);
                    ovc  = int'(vc_a[i][v]);
                    if (req_a[i][v] && port < P && !(pgv[i] == 1 && pgvc[i] == v)) begin
                        if (credit_m[port][ovc] > 0) begin
                            d = (v - in_ptr_m[i] + V) % V;
                            if (d < bd) begin bd = d; s1[i] = v; end
                        end
                    end
                end
            end
            for (int o = 0; o < P; o++) begin
                bd = P;
                w = -1;
                for (int i = 0; i < P; i++) begin
                    if (s1[i] >= 0) begin
                        if (int'(port_a[i][s1[i]]) == o) begin
                            d = (i - out_ptr_m[o] + P) % P;
                            if (d < bd) begin bd = d; w = i; end
                        end
                    end
                end
                if (w >= 0) begin
                    xv_m[o] = 1; xsel_m[o] = w; gv_m[w] = 1; gvc_m[w] = s1[w];
                    delta[o][int'(vc_a[w][s1[w]])] = -1;
                end
            end
            for (int o = 0; o < P; o++) begin
                if (cv_a[o]) begin
                    c = int'(cvc_a[o]);
                    if (delta[o][c] == 0 && credit_m[o][c] == BS) err_m = 1;
                    else delta[o][c] = delta[o][c] + 1;
                end
            end
            for (int o = 0; o < P; o++) begin
                for (int v = 0; v < V; v++) credit_m[o][v] = credit_m[o][v] + delta[o][v];
                if (xv_m[o] == 1) begin
                    out_ptr_m[o] = (xsel_m[o] + 1) % P;
                    in_ptr_m[xsel_m[o]] = (gvc_m[xsel_m[o]] + 1) % V;
                end
            end
        end
        for (int i = 0; i < P; i++) begin
            exp_gv[i]             = (gv_m[i] == 1);
            exp_gvc[i*VS +: VS]   = VS'(gvc_m[i]);
            exp_xv[i]             = (xv_m[i] == 1);
            exp_xsel[i*PS +: PS]  = PS'(xsel_m[i]);
        end
        exp_err = (err_m == 1);
    endtask

    // Cycle-by-cycle comparison against the model, sampled 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("grant_valid", 32'(grant_valid_s), 32'(exp_gv));
            chk("grant_vc",    32'(grant_vc_s),    32'(exp_gvc));
            chk("xbar_valid",  32'(xbar_valid_s),  32'(exp_xv));
            chk("xbar_sel",    32'(xbar_sel_s),    32'(exp_xsel));
            chk("credit_err",  32'(credit_err_s),  32'(exp_err));
        end
    end

    task automatic step();
        predict();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < P; i++) begin
            for (int v = 0; v < V; v++) begin
                req_a[i][v] = 1'b0; port_a[i][v] = 3'd0; vc_a[i][v] = 2'd0;
            end
            cv_a[i] = 1'b0; cvc_a[i] = 2'd0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < P; i++) begin
            gv_m[i] = 0; gvc_m[i] = 0; xv_m[i] = 0; xsel_m[i] = 0;
        end
        err_m = 0;

        // Reset then a single LOCAL vc0 -> EAST vc2 request
        do_reset();
        chk("reset_gv", 32'(grant_valid_s), 32'd0);
        chk("reset_xv", 32'(xbar_valid_s), 32'd0);
        chk("reset_err", 32'(credit_err_s), 32'd0);
        chk("model_reset_credit", 32'(credit_m[3][1]), 32'd8);
        req_a[0][0] = 1'b1; port_a[0][0] = 3'd4; vc_a[0][0] = 2'd2;
        step();
        req_a[0][0] = 1'b0;
        chk("single_gv", 32'(grant_valid_s), 32'b00001);
        chk("single_gvc", 32'(grant_vc_s[1:0]), 32'd0);
        chk("single_xv", 32'(xbar_valid_s), 32'b10000);
        chk("single_xsel", 32'(xbar_sel_s[14:12]), 32'd0);
        chk("model_credit_after", 32'(credit_m[4][2]), 32'd7);
        step();
        chk("single_gone", 32'(grant_valid_s), 32'd0);

        // Output contention NORTH vc1 and WEST vc3 -> SOUTH, then reset mid-burst
        do_reset();
        req_a[1][1] = 1'b1; port_a[1][1] = 3'd2; vc_a[1][1] = 2'd0;
        req_a[3][3] = 1'b1; port_a[3][3] = 3'd2; vc_a[3][3] = 2'd1;
        seq = '{1, 3, 1, 3};
        for (int k = 0; k < 4; k++) begin
            step();
            chk("contend_sel", 32'(xbar_sel_s[8:6]), 32'(seq[k]));
            chk("contend_gv", 32'(grant_valid_s), 32'(1 << seq[k]));
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_gv", 32'(grant_valid_s), 32'd0);
        chk("midrst_xv", 32'(xbar_valid_s), 32'd0);
        chk("midrst_xsel", 32'(xbar_sel_s), 32'd0);
        step();
        chk("post_rst_sel", 32'(xbar_sel_s[8:6]), 32'd1);
        chk("post_rst_xv", 32'(xbar_valid_s), 32'b00100);

        // Credit exhaustion on EAST vc0, then a single return
        do_reset();
        req_a[0][0] = 1'b1; port_a[0][0] = 3'd4; vc_a[0][0] = 2'd0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (grant_valid_s[0]) cnt++;
        end
        chk("exhaust_count", 32'(cnt), 32'd8);
        cv_a[4] = 1'b1; cvc_a[4] = 2'd0;
        step();
        cv_a[4] = 1'b0;
        chk("return_plus1", 32'(grant_valid_s[0]), 32'd0);
        step();
        chk("return_plus2", 32'(grant_valid_s[0]), 32'd1);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (grant_valid_s[0]) cnt++;
        end
        chk("after_return_count", 32'(cnt), 32'd0);

        // VC round-robin within WEST
        do_reset();
        req_a[3][0] = 1'b1; port_a[3][0] = 3'd0;
        req_a[3][1] = 1'b1; port_a[3][1] = 3'd1;
        req_a[3][2] = 1'b1; port_a[3][2] = 3'd4;
        seq = '{0, 1, 2, 0};
        for (int k = 0; k < 4; k++) begin
            step();
            chk("vc_rr_gv", 32'(grant_valid_s), 32'b01000);
            chk("vc_rr_vc", 32'(grant_vc_s[7:6]), 32'(seq[k]));
        end

        // Simultaneous grant and return at full credit, then a lone return
        do_reset();
        req_a[0][0] = 1'b1; port_a[0][0] = 3'd4; vc_a[0][0] = 2'd0;
        cv_a[4] = 1'b1; cvc_a[4] = 2'd0;
        step();
        clear_inputs();
        chk("simul_gv", 32'(grant_valid_s[0]), 32'd1);
        chk("simul_err", 32'(credit_err_s), 32'd0);
        chk("model_simul_credit", 32'(credit_m[4][0]), 32'd8);
        step();
        chk("simul_err_hold", 32'(credit_err_s), 32'd0);
        cv_a[4] = 1'b1; cvc_a[4] = 2'd0;
        step();
        cv_a[4] = 1'b0;
        chk("overflow_err", 32'(credit_err_s), 32'd1);
        step();
        chk("overflow_sticky", 32'(credit_err_s), 32'd1);

        // Illegal output port is ignored
        do_reset();
        req_a[0][0] = 1'b1; port_a[0][0] = 3'd6;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bad_port_gv", 32'(grant_valid_s), 32'd0);
            chk("bad_port_xv", 32'(xbar_valid_s), 32'd0);
        end

        // Randomized traffic with occasional illegal ports, returns and resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < P; i++) begin
                for (int v = 0; v < V; v++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_a[i][v] = 1'($urandom_range(0, 1));
                        port_a[i][v] = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4))
                                                                   : 3'($urandom_range(5, 7));
                        vc_a[i][v] = 2'($urandom_range(0, 3));
                    end
                end
                cv_a[i]  = ($urandom_range(0, 9) == 0);
                cvc_a[i] = 2'($urandom_range(0, 3));
            end
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/noc_switch_allocator.md
Name: noc_switch_allocator

Overview:
- Separable input-first switch allocator for one mesh router. Each cycle it picks at most one input VC per input port and at most one input port per output port.
- Only input VCs whose target downstream VC has a credit are eligible.
- Drives crossbar select lines and input-buffer dequeue grants, and keeps per-output-VC credit counters.
- Sits between the per-input VC buffers and the PORT_NUM x PORT_NUM crossbar. Flits use the flit_t format: 512-bit port, VC id in header.

Parameters:
PORT_NUM, 5, router ports (port_t encoding: LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4)
VC_NUM, 4, VCs per port; VC_SIZE = clog2(VC_NUM)
BUFFER_SIZE, 8, downstream flit buffer depth per VC; initial credit value
PORT_SIZE, clog2(PORT_NUM)=3, port index width; CNT_W = clog2(BUFFER_SIZE+1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
req_i  in  PORT_NUM*VC_NUM  per input VC: head flit waiting; index = in_port*VC_NUM+vc
out_port_i  in  PORT_NUM*VC_NUM*PORT_SIZE  per input VC: requested output port
out_vc_i  in  PORT_NUM*VC_NUM*VC_SIZE  per input VC: downstream VC already assigned by VC allocation
credit_valid_i  in  PORT_NUM  per output port: one credit returned this cycle
credit_vc_i  in  PORT_NUM*VC_SIZE  per output port: VC of returned credit
grant_valid_o  out  PORT_NUM  per input port: dequeue one flit
grant_vc_o  out  PORT_NUM*VC_SIZE  per input port: granted VC
xbar_valid_o  out  PORT_NUM  per output port: crossbar drives flit this cycle
xbar_sel_o  out  PORT_NUM*PORT_SIZE  per output port: selected input port
credit_err_o  out  1  sticky: credit returned to a full counter

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs are 0.
  - All credit counters are BUFFER_SIZE.
  - All round-robin pointers are 0.
  - Reset mid-operation discards pending allocation; no grant is issued on the first cycle after reset.
- Eligibility in cycle t: input VC (i,v) is eligible iff all of:
  - req_i=1
  - out_port_i < PORT_NUM; values 5..7 are ignored silently
  - credit[out_port][out_vc] > 0
  - (i,v) was not granted in cycle t-1. This mask prevents a double grant while the requester reacts.
- Stage 1, per input i: round-robin over eligible VCs, starting at in_ptr[i].
- Stage 2, per output o: round-robin over inputs whose stage-1 winner targets o, starting at out_ptr[o].
- Outputs are registered; latency is 1 cycle.
  - For each (i,v) winning both stages in cycle t, at edge t+1: grant_valid_o[i]=1, grant_vc_o[i]=v, xbar_valid_o[o]=1, xbar_sel_o[o]=i.
  - All are valid during cycle t+1 only. The requester dequeues in t+1 and presents its next head flit from t+2.
- Pointer update, only on a two-stage win:
  - out_ptr[o] <= i+1 mod PORT_NUM.
  - in_ptr[i] <= v+1 mod VC_NUM.
  - A stage-1 winner that loses stage 2 leaves in_ptr[i] unchanged.
  - Losers keep their requests; no state is needed.
- Credits, one CNT_W counter per (output, VC):
  - Decrement on grant to it.
  - Increment on credit_valid_i for it.
  - Simultaneous grant and return: no change.
  - Never goes below 0, since a grant requires >0.
  - Return at BUFFER_SIZE with no same-cycle grant: counter holds and credit_err_o is set until reset.
- Conservation: at most one grant per input and one per output per cycle. No two inputs may share an output in the same cycle.
- U-turns (out_port == in_port) are legal; routing excludes them.

Test Plan:
- Reset, then idle:
  - All outputs 0 and all credits 8.
  - req_i[0] (LOCAL vc0 -> EAST vc2) held 1 cycle -> cycle later grant_valid_o[0]=1, grant_vc_o[0]=0, xbar_valid_o[4]=1, xbar_sel_o[4]=0; credit[4][2]=7.
- Output contention: NORTH vc1 and WEST vc3 both request SOUTH, held continuously:
  - Grants alternate inputs 1,3,1,3 on cycles 1,2,3,4.
  - xbar_sel_o[2] follows the alternation.
  - The double-grant mask must not stall the alternation.
- Credit exhaustion:
  - LOCAL vc0 -> EAST vc0 held with no returns -> exactly 8 grants, then none.
  - One credit_valid_i[4] with vc 0 -> exactly one more grant 2 cycles later.
- VC round-robin within input: WEST vc0, vc1, vc2 all request distinct free outputs, held -> granted VCs 0,1,2,0 in order.
- Simultaneous grant and credit return to the same output VC at credit 8 -> stays 8, credit_err_o=0. A second return alone at 8 -> credit_err_o=1.
- Corner inputs and reset:
  - out_port_i=6 with req=1 -> no grant ever.
  - rst_n=0 in the middle of a contention burst -> next cycle all outputs 0 and credits 8; pointers restart at 0.
